// File: rtl/simple_pkg.sv
// Shared types and encodings for the SIMPLE 16-bit controller:
// state encoding, opcode class constants, branch conditions, flag bit positions.
package simple_pkg;

    // Phase encoding is visible on the phase output, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd7
    } state_t;

    // op1 = IR[15:14]
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 = IR[13:11], meaningful only in the OP1_BR class
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // op3 = IR[7:4], meaningful only in the OP1_ALU class
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // cond = IR[10:8]
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // flags = {S,Z,C,V}
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic ld;
        logic st;
        logic alu;
        logic li;
        logic b;
        logic bcc;
        logic cmp;
        logic out;
        logic hlt;
    } iclass_t;

    // Classify an instruction word. The all-zero word is a NOP, so it is
    // carved out of the LD class (which otherwise shares op1=00).
    function automatic iclass_t decode(input logic [15:0] ir);
        iclass_t    c;
        logic [1:0] op1;
        logic [2:0] op2;
        logic [3:0] op3;
        logic       nop;
        op1   = ir[15:14];
        op2   = ir[13:11];
        op3   = ir[7:4];
        nop   = (ir == 16'h0000);
        c     = '0;
        c.ld  = (op1 == OP1_LD) && !nop;
        c.st  = (op1 == OP1_ST);
        c.alu = (op1 == OP1_ALU);
        c.li  = (op1 == OP1_BR) && (op2 == OP2_LI);
        c.b   = (op1 == OP1_BR) && (op2 == OP2_B);
        c.bcc = (op1 == OP1_BR) && (op2 == OP2_BCC);
        c.cmp = c.alu && (op3 == OP3_CMP);
        c.out = c.alu && (op3 == OP3_OUT);
        c.hlt = c.alu && (op3 == OP3_HLT);
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Conditional-branch resolver: maps the 3-bit condition code and the
// current {S,Z,C,V} flags to a taken bit. Purely combinational.
module branch_cond
    import simple_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic s;
    logic z;
    logic v;
    logic unused_carry;

    assign s = flags[FLAG_S];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    // No condition currently tests carry.
    assign unused_carry = flags[FLAG_C];

    // Evaluate the condition; reserved codes are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = z;
            COND_BLT: taken = s ^ v;
            COND_BLE: taken = z | (s ^ v);
            COND_BNE: taken = ~z;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Phase-sequencing controller for the SIMPLE datapath. Steps each
// instruction through IF/ID/EX/(MEM)/WB so every write strobe fires once,
// with run/stop, single-step, halt and a configurable memory wait count.
//
// exec and step are single-cycle pulses sampled on every rising clock edge;
// there is no acknowledge. exec toggles the run latch (except in HALT);
// step is honoured only in IDLE while stopped and without a coincident exec.
module multicycle_controller
    import simple_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        step,
    input  logic [15:0] instr,
    input  logic [3:0]  flags,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        mem_we,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        flags_we,
    output logic        out_we,
    output logic        running,
    output logic        halted,
    output logic [2:0]  phase
);

    state_t     state;
    state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0] ir;
    logic       step_armed;
    logic       wait_done;
    logic       step_take;
    logic       bcc_taken;
    logic       level_valid;
    iclass_t    ic;

    assign ic        = decode(ir);
    assign wait_done = (cnt == CNT_W'(MEM_LAT - 1));
    assign step_take = (state == ST_IDLE) && step && !running && !exec;
    assign phase     = state;

    branch_cond u_branch_cond (
        .cond  (ir[10:8]),
        .flags (flags),
        .taken (bcc_taken)
    );

    // State register plus run/halt/step latches and the held instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            halted     <= 1'b0;
            step_armed <= 1'b0;
            ir         <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (exec && state != ST_HALT)
                running <= ~running;
            if (state == ST_EX && ic.hlt)
                halted <= 1'b1;
            if (step_take)
                step_armed <= 1'b1;
            else if (state == ST_WB)
                step_armed <= 1'b0;
            if (ir_we)
                ir <= instr;
        end
    end

    // Wait counter: counts up while dwelling in IF or MEM, zero on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if ((state == ST_IF || state == ST_MEM) && state_nxt == state)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end

    // Next-state logic. A stepped instruction always returns to IDLE even if
    // exec started the run latch meanwhile, so a step is exactly one instruction.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (running || step_take) state_nxt = ST_IF;
            ST_IF:   if (wait_done) state_nxt = ST_ID;
            ST_ID:   state_nxt = ST_EX;
            ST_EX: begin
                if (ic.hlt)
                    state_nxt = ST_HALT;
                else if (ic.ld || ic.st)
                    state_nxt = ST_MEM;
                else
                    state_nxt = ST_WB;
            end
            ST_MEM:  if (wait_done) state_nxt = ST_WB;
            ST_WB:   state_nxt = (running && !step_armed) ? ST_IF : ST_IDLE;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: one-cycle strobes keyed on state, level selects held
    // from ID through WB so the datapath sees them settled before write-back.
    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        flags_we    = 1'b0;
        out_we      = 1'b0;
        level_valid = (state == ST_ID) || (state == ST_EX) ||
                      (state == ST_MEM) || (state == ST_WB);
        mem_to_reg  = level_valid && ic.ld;
        reg_dst     = level_valid && !ic.ld;
        alu_src     = level_valid && (ic.ld || ic.st);
        case (state)
            ST_IF:  ir_we  = wait_done;
            ST_MEM: mem_we = wait_done && ic.st;
            ST_WB: begin
                pc_we    = 1'b1;
                pc_src   = ic.b || (ic.bcc && bcc_taken);
                reg_we   = ic.ld || ic.li ||
                           (ic.alu && !ic.cmp && !ic.out && !ic.hlt);
                flags_we = ic.alu && !ic.out && !ic.hlt;
                out_we   = ic.out;
            end
            default: ;
        endcase
    end

endmodule
